// File: rtl/vt_frame_serializer_6b.sv
// Word-to-bit serializer feeding a fixed-alignment frame detector.
// A small FIFO buffers words; frames go out back-to-back, with idle frames when the FIFO is empty.
module vt_frame_serializer_6b #(
    parameter int                 FRAME_W    = 6,
    parameter int                 FIFO_DEPTH = 4,
    parameter logic [FRAME_W-1:0] IDLE_WORD  = {FRAME_W{1'b0}}
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic [FRAME_W-1:0]              i_data,
    input  logic                            i_valid,
    output logic                            o_ready,
    output logic                            o_SI,
    output logic                            o_frame_start,
    output logic                            o_frame_valid,
    output logic [$clog2(FIFO_DEPTH):0]     o_fifo_level,
    output logic [7:0]                      o_idle_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(FRAME_W);

    logic [FRAME_W-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [LVL_W-1:0]   level_r;
    logic [LVL_W-1:0]   level_nxt_s;

    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic [FRAME_W-1:0] shreg_r;
    logic [FRAME_W-1:0] shreg_nxt_s;
    logic               frame_valid_r;
    logic               frame_valid_nxt_s;
    logic [7:0]         idle_cnt_r;
    logic [7:0]         idle_cnt_nxt_s;

    logic               push_s;
    logic               pop_s;
    logic               last_bit_s;

    // Ready depends only on the registered level, never on a same-edge pop.
    assign o_ready    = i_rst_n && (level_r < LVL_W'(FIFO_DEPTH));
    assign push_s     = i_valid && o_ready;
    assign last_bit_s = (cnt_r == CNT_W'(FRAME_W - 1));

    // Bit counter, shift register, frame qualifier and idle counter next-state.
    always_comb begin
        cnt_nxt_s         = cnt_r;
        shreg_nxt_s       = shreg_r;
        frame_valid_nxt_s = frame_valid_r;
        idle_cnt_nxt_s    = idle_cnt_r;
        pop_s             = 1'b0;
        if (last_bit_s) begin
            cnt_nxt_s = {CNT_W{1'b0}};
            if (level_r != {LVL_W{1'b0}}) begin
                pop_s             = 1'b1;
                shreg_nxt_s       = mem_r[rd_ptr_r];
                frame_valid_nxt_s = 1'b1;
            end else begin
                shreg_nxt_s       = IDLE_WORD;
                frame_valid_nxt_s = 1'b0;
                if (idle_cnt_r != 8'hFF) begin
                    idle_cnt_nxt_s = idle_cnt_r + 8'd1;
                end else begin
                    idle_cnt_nxt_s = idle_cnt_r;
                end
            end
        end else begin
            cnt_nxt_s   = cnt_r + CNT_W'(1);
            shreg_nxt_s = {shreg_r[FRAME_W-2:0], 1'b0};
        end
    end

    // FIFO occupancy: a simultaneous push and pop leaves the level unchanged.
    always_comb begin
        level_nxt_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + LVL_W'(1);
            2'b01:   level_nxt_s = level_r - LVL_W'(1);
            default: level_nxt_s = level_r;
        endcase
    end

    // Serializer state registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_r         <= {CNT_W{1'b0}};
            shreg_r       <= IDLE_WORD;
            frame_valid_r <= 1'b0;
            idle_cnt_r    <= 8'd0;
        end else begin
            cnt_r         <= cnt_nxt_s;
            shreg_r       <= shreg_nxt_s;
            frame_valid_r <= frame_valid_nxt_s;
            idle_cnt_r    <= idle_cnt_nxt_s;
        end
    end

    // FIFO pointers and level; reset discards anything queued.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            level_r <= level_nxt_s;
        end
    end

    // FIFO storage.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= IDLE_WORD;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= i_data;
        end
    end

    assign o_SI          = shreg_r[FRAME_W-1];
    assign o_frame_start = (cnt_r == {CNT_W{1'b0}});
    assign o_frame_valid = frame_valid_r;
    assign o_fifo_level  = level_r;
    assign o_idle_cnt    = idle_cnt_r;

endmodule

// File: doc/vt_frame_serializer_6b.md
# vt_frame_serializer_6b

Upstream feeder for the 6-bit non-overlapping sequence detector. It accepts 6-bit words over a valid/ready handshake and buffers them in a small FIFO. It shifts them out MSB-first as a continuous serial stream of back-to-back 6-bit frames, so the detector's fixed frame alignment always holds. When no data is queued it inserts idle frames, so the bit stream never stalls and frame boundaries never drift.

## Interface
- FRAME_W, 6, bits per frame; must match the detector's frame length
- FIFO_DEPTH, 4, word buffer entries; power of two, ≥2
- IDLE_WORD, 6'b000000, fill pattern for empty frames; must never equal a pattern the downstream detector matches
- Clocking and reset (already decided): one clock; reset is asynchronous and active-low
- i_clk  in  1  single clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_data  in  FRAME_W  parallel word, bit FRAME_W-1 sent first
- i_valid  in  1  i_data valid this cycle
- o_ready  out  1  FIFO can accept a word this cycle
- o_SI  out  1  serial bit; drives detector i_SI
- o_frame_start  out  1  high during bit 0 of every frame
- o_frame_valid  out  1  high for all FRAME_W bits of a frame carrying real data
- o_fifo_level  out  clog2(FIFO_DEPTH)+1  words currently queued
- o_idle_cnt  out  8  saturating count of idle frames loaded

## Operation
- Write: the FIFO pushes i_data on a rising edge when i_valid && o_ready. o_ready = i_rst_n && (o_fifo_level < FIFO_DEPTH). It is combinational from the registered level and has no dependency on a same-edge pop.
- Bit counter cnt counts 0..FRAME_W-1 and wraps. It advances every cycle unconditionally.
- Shift register shreg has width FRAME_W. o_SI = shreg[FRAME_W-1].
- Edge with cnt != FRAME_W-1: shreg shifts left by one, and cnt increments.
- Edge with cnt == FRAME_W-1 (the load edge): cnt goes to 0.
  - If the FIFO is non-empty, the head word is popped into shreg, and the frame_valid register is set to 1.
  - Otherwise IDLE_WORD is loaded, frame_valid is cleared to 0, and o_idle_cnt increments, saturating at 255.
- There is no write-to-pop bypass. A word written on a load edge is not visible to that same load.
- Simultaneous push and pop on one edge: level is unchanged and data order is preserved.
- FIFO order is strict first-in first-out. Read and write pointers wrap modulo FIFO_DEPTH.
- o_frame_start = (cnt == 0). o_frame_valid = frame_valid register.
- Reset values, applied asynchronously on i_rst_n low:
  - cnt=0, shreg=IDLE_WORD, so o_SI=IDLE_WORD[FRAME_W-1]=0 by default
  - o_frame_start=1, o_frame_valid=0, o_fifo_level=0, o_ready=0, o_idle_cnt=0
  - FIFO pointers cleared, and queued data discarded
- Reset mid-frame: the partial frame is abandoned. The downstream detector must be reset or re-aligned by the same reset.

## Timing
- Cycle 0 is the first cycle after i_rst_n rises. It carries bit 0 of an idle frame that is not counted in o_idle_cnt.
- Frame n occupies cycles 6n..6n+5. Load edges fall at the end of cycles 6n+5.
- Write-to-first-bit latency is 1 to 6 cycles, measured from the accepting edge to the first cycle o_SI carries the MSB.
  - 1 cycle when the write edge precedes a load edge by exactly one cycle.
  - 6 cycles when the write lands on a load edge.
- A full FIFO drains one word per 6 cycles. Sustained input above 1 word per 6 cycles back-pressures through o_ready.
- All outputs except o_ready and o_frame_start are direct register outputs. o_frame_start decodes from cnt.

## Test plan
- Idle stream: release reset, no writes for 24 cycles.
  - o_SI=0 throughout, and o_frame_start high in cycles 0, 6, 12 and 18.
  - o_frame_valid=0 throughout.
  - o_idle_cnt=4 in cycle 24.
- Single match: write 6'b100110 in cycle 2.
  - Popped at the end of cycle 5.
  - o_SI in cycles 6–11 = 1,0,0,1,1,0, with o_frame_valid high in cycles 6–11.
  - Detector o_f=1 in cycle 11.
- Back-pressure: i_valid held high with words A, B, C, D, E presented from cycle 0.
  - A–D accepted in cycles 0–3, and o_fifo_level=4 in cycle 4.
  - o_ready=0 in cycles 4–5. E is accepted in cycle 6.
  - A–E emitted in order in frames 1–5, with o_frame_valid continuously high in cycles 6–35.
- Simultaneous push/pop: level 2, with a write on the load edge at the end of cycle 11.
  - o_fifo_level stays 2 and the order is intact.
- Async reset: assert i_rst_n low mid-cycle 8 with 3 words queued.
  - Outputs take reset values immediately, without waiting for a clock edge, and o_fifo_level=0.
  - After release, o_frame_start=1 in the new cycle 0, and the discarded words never appear.
- Saturation: 300 idle frames, i.e. 1800 cycles, with no writes.
  - o_idle_cnt=255 and stays 255.
